// File: rtl/relu_bp_pkg.sv
// relu_bp_pkg: shared types and helpers for the ReLU backward-pass layer.
//   state_t    : control states of the serial gradient pass
//   LEAK_SHIFT : right-shift applied to masked gradients in the leaky build
//                (slope 1/8)
//   z_positive : strict signed-positive test from the sign bit and a
//                nonzero flag
package relu_bp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam int LEAK_SHIFT = 3;

   // z > 0 as a signed value. Zero and the most negative value both fail.
   function automatic logic z_positive(input logic sign_bit, input logic nonzero);
      return !sign_bit && nonzero;
   endfunction

endpackage

// File: rtl/relu_grad_cell.sv
// relu_grad_cell: combinational ReLU-derivative for one gradient element.
//   mask_bit : 1 when the forward pre-activation was positive
//   grad     : upstream gradient dA (signed)
//   dz       : dA when mask_bit is set, otherwise 0 (or dA >>> LEAK_SHIFT
//              when RELU_BP_LEAKY_EN is defined)
// Configuration macro: RELU_BP_LEAKY_EN
import relu_bp_pkg::*;

module relu_grad_cell #(
   parameter int DATA_WIDTH = 24
) (
   input  logic                  mask_bit,
   input  logic [DATA_WIDTH-1:0] grad,
   output logic [DATA_WIDTH-1:0] dz
);

   logic [DATA_WIDTH-1:0] leak;

`ifdef RELU_BP_LEAKY_EN
   // Arithmetic shift keeps the sign, which matches a 1/8 forward slope
   // for negative pre-activations.
   assign leak = DATA_WIDTH'($signed(grad) >>> LEAK_SHIFT);
`else
   assign leak = '0;
`endif

   assign dz = mask_bit ? grad : leak;

endmodule

// File: rtl/relu_backprop_layer.sv
// relu_backprop_layer: backward pass of a ReLU activation layer.
// Captures NUM_NODES pre-activations in parallel as a one-bit mask per node.
// It then streams the upstream gradient through a single-entry output
// register, producing dZ[i] = mask[i] ? dA[i] : 0.
//   clk, rst_n                : clock, async active-low reset
//   zin_valid/zin_ready, zin  : parallel capture of pre-activations
//   grad_in_valid/ready, grad_in : serial upstream gradient
//   grad_out_valid/ready, grad_out, grad_out_last : serial dZ stream
//   busy                      : high whenever a pass is in progress
// Configuration macro: RELU_BP_LEAKY_EN (leaky masked elements, in relu_grad_cell)
import relu_bp_pkg::*;

module relu_backprop_layer #(
   parameter int DATA_WIDTH = 24,
   parameter int NUM_NODES  = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  zin_valid,
   input  logic [DATA_WIDTH-1:0] zin [NUM_NODES],
   output logic                  zin_ready,
   input  logic                  grad_in_valid,
   output logic                  grad_in_ready,
   input  logic [DATA_WIDTH-1:0] grad_in,
   output logic                  grad_out_valid,
   input  logic                  grad_out_ready,
   output logic [DATA_WIDTH-1:0] grad_out,
   output logic                  grad_out_last,
   output logic                  busy
);

   localparam int IDX_W = $clog2(NUM_NODES);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_NODES - 1);

   state_t                state, state_nxt;
   logic [NUM_NODES-1:0]  mask, mask_cap;
   logic [IDX_W-1:0]      idx;
   logic                  idx_last;
   logic                  accept, handoff;
   logic [DATA_WIDTH-1:0] cell_dz;

   // Per-node sign test, evaluated on the live zin bus and latched on capture.
   generate
      for (genvar i = 0; i < NUM_NODES; i++) begin : g_mask
         assign mask_cap[i] = z_positive(zin[i][DATA_WIDTH-1], |zin[i]);
      end
   endgenerate

   assign zin_ready     = (state == IDLE);
   assign busy          = (state != IDLE);
   // The output register may take a new element while its current one is
   // being popped in the same cycle, which gives one element per cycle.
   assign grad_in_ready = (state == STREAM) && (!grad_out_valid || grad_out_ready);
   assign accept        = grad_in_valid && grad_in_ready;
   assign handoff       = grad_out_valid && grad_out_ready;
   assign idx_last      = (idx == IDX_MAX);

   relu_grad_cell #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_cell (
      .mask_bit (mask[idx]),
      .grad     (grad_in),
      .dz       (cell_dz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (zin_valid)                 state_nxt = STREAM;
         STREAM:  if (accept && idx_last)        state_nxt = DRAIN;
         DRAIN:   if (handoff && grad_out_last)  state_nxt = IDLE;
         default:                                state_nxt = IDLE;
      endcase
   end

   // Mask and element index. Capture is only honoured in IDLE, so a stray
   // zin_valid during a pass leaves the mask alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask <= '0;
         idx  <= '0;
      end else if (state == IDLE && zin_valid) begin
         mask <= mask_cap;
         idx  <= '0;
      end else if (accept) begin
         idx  <= idx_last ? '0 : idx + 1'b1;
      end
   end

   // Single-entry output register. Data and last only change on accept,
   // so they hold under backpressure and after a plain handoff.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grad_out_valid <= 1'b0;
         grad_out       <= '0;
         grad_out_last  <= 1'b0;
      end else if (accept) begin
         grad_out_valid <= 1'b1;
         grad_out       <= cell_dz;
         grad_out_last  <= idx_last;
      end else if (handoff) begin
         grad_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_relu_backprop_layer.sv
module tb_relu_backprop_layer;

   localparam int DW = 24;
   localparam int NN = 20;

   // Expected outputs for masked entries of the directed table.
`ifdef RELU_BP_LEAKY_EN
   localparam logic [DW-1:0] L100 = 24'd12;       // 100 / 8, floored
   localparam logic [DW-1:0] LM1  = 24'hFFFFFF;   // -1 / 8 floored = -1
   localparam logic [DW-1:0] LM64 = 24'hFFFFF8;   // -64 / 8 = -8
`else
   localparam logic [DW-1:0] L100 = 24'd0;
   localparam logic [DW-1:0] LM1  = 24'd0;
   localparam logic [DW-1:0] LM64 = 24'd0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          zin_valid;
   logic [DW-1:0] zin [NN];
   logic          zin_ready;
   logic          grad_in_valid;
   logic          grad_in_ready;
   logic [DW-1:0] grad_in;
   logic          grad_out_valid;
   logic          grad_out_ready;
   logic [DW-1:0] grad_out;
   logic          grad_out_last;
   logic          busy;

   always #5 clk = ~clk;

   relu_backprop_layer #(.DATA_WIDTH(DW), .NUM_NODES(NN)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .zin_valid      (zin_valid),
      .zin            (zin),
      .zin_ready      (zin_ready),
      .grad_in_valid  (grad_in_valid),
      .grad_in_ready  (grad_in_ready),
      .grad_in        (grad_in),
      .grad_out_valid (grad_out_valid),
      .grad_out_ready (grad_out_ready),
      .grad_out       (grad_out),
      .grad_out_last  (grad_out_last),
      .busy           (busy)
   );

   typedef struct {
      logic [DW-1:0] z;
      logic [DW-1:0] g;
      logic [DW-1:0] e;
   } vec_t;

   vec_t          tbl [NN];
   logic [DW-1:0] zv [NN];
   logic [DW-1:0] gv [NN];
   logic [DW-1:0] ev [NN];
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: ReLU derivative from the signed value of z.
   function automatic logic [DW-1:0] model(input logic [DW-1:0] z, input logic [DW-1:0] g);
      if ($signed(z) > 0) return g;
`ifdef RELU_BP_LEAKY_EN
      begin
         int v;
         v = int'($signed(g));
         return DW'((v - (((v % 8) + 8) % 8)) / 8);
      end
`else
      return '0;
`endif
   endfunction

   function automatic logic [DW-1:0] rand_z();
      case ($urandom_range(5))
         0:       return 24'h000000;
         1:       return 24'h800000;
         2:       return 24'h000001;
         3:       return 24'hFFFFFF;
         default: return DW'($urandom);
      endcase
   endfunction

   task automatic capture();
      @(negedge clk);
      for (int i = 0; i < NN; i++) zin[i] = zv[i];
      zin_valid = 1'b1;
      #1;
      check("cap_zin_ready", DW'(zin_ready), DW'(1));
      @(negedge clk);
      zin_valid = 1'b0;
      #1;
      check("cap_busy", DW'(busy), DW'(1));
      check("cap_zin_ready_low", DW'(zin_ready), DW'(0));
   endtask

   // Drives the gradient stream and scores each handoff against ev[].
   // Stops after 'limit' handoffs (NN for a full pass).
   task automatic run_stream(input int stall_pct, input int ws, input int we, input int gap_pct,
                             input int inject_at, input int limit, output int cycles);
      int            sent, recv, cyc;
      logic          held, hl;
      logic [DW-1:0] hv;
      sent = 0; recv = 0; cyc = 0; held = 1'b0; hl = 1'b0; hv = '0;
      while (recv < limit && cyc < 3000) begin
         @(negedge clk);
         grad_out_ready = !(cyc >= ws && cyc < we) && (int'($urandom_range(99)) >= stall_pct);
         grad_in_valid  = (sent < NN) && (int'($urandom_range(99)) >= gap_pct);
         grad_in        = (sent < NN) ? gv[sent] : '0;
         zin_valid      = (cyc == inject_at);
         if (cyc == inject_at)
            for (int i = 0; i < NN; i++) zin[i] = 24'h000123;
         #1;
         if (cyc == inject_at) check("ignored_zin_ready", DW'(zin_ready), DW'(0));
         if (held) begin
            check("hold_valid", DW'(grad_out_valid), DW'(1));
            check("hold_data", grad_out, hv);
            check("hold_last", DW'(grad_out_last), DW'(hl));
         end
         if (grad_out_valid && !grad_out_ready)
            check("bp_in_ready", DW'(grad_in_ready), DW'(0));
         if (grad_out_valid && grad_out_ready) begin
            check($sformatf("data[%0d]", recv), grad_out, ev[recv]);
            check($sformatf("last[%0d]", recv), DW'(grad_out_last), DW'(recv == NN - 1));
            recv++;
         end
         if (grad_in_valid && grad_in_ready) sent++;
         held = grad_out_valid && !grad_out_ready;
         hv   = grad_out;
         hl   = grad_out_last;
         cyc++;
      end
      if (recv < limit) begin
         errors++;
         $display("FAIL stream_timeout: received %0d of %0d", recv, limit);
      end
      cycles = cyc;
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      grad_in_valid = 1'b0;
      zin_valid     = 1'b0;
      #1;
      check({tag, "_busy"}, DW'(busy), DW'(0));
      check({tag, "_zin_ready"}, DW'(zin_ready), DW'(1));
      check({tag, "_out_valid"}, DW'(grad_out_valid), DW'(0));
   endtask

   task automatic load_table();
      for (int i = 0; i < NN; i++) begin
         zv[i] = tbl[i].z; gv[i] = tbl[i].g; ev[i] = tbl[i].e;
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < NN; i++) begin
         zv[i] = rand_z();
         gv[i] = DW'($urandom);
         ev[i] = model(zv[i], gv[i]);
      end
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0; zin_valid = 1'b0; grad_in_valid = 1'b0; grad_in = '0;
      grad_out_ready = 1'b1;
      for (int i = 0; i < NN; i++) zin[i] = '0;

      // Directed table: mask basics and signed edges.
      tbl[0] = '{24'd5,       24'd100,    24'd100};
      tbl[1] = '{24'd0,       24'd100,    L100};
      tbl[2] = '{-24'sd3,     24'd100,    L100};
      tbl[3] = '{24'h800000,  24'hFFFFFF, LM1};
      tbl[4] = '{24'h000001,  24'hFFFFFF, 24'hFFFFFF};
      tbl[5] = '{24'hFFFFFF,  24'hFFFFC0, LM64};
      tbl[6] = '{24'h7FFFFF,  24'h800000, 24'h800000};
      for (int i = 7; i < NN; i++)
         tbl[i] = (i % 2 == 0) ? '{DW'(i), 24'd100, 24'd100} : '{-DW'(i), 24'd100, L100};

      // Reset state
      #12;
      check("rst_out_valid", DW'(grad_out_valid), DW'(0));
      check("rst_out", grad_out, DW'(0));
      check("rst_last", DW'(grad_out_last), DW'(0));
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_in_ready", DW'(grad_in_ready), DW'(0));
      check("rst_zin_ready", DW'(zin_ready), DW'(1));
      @(negedge clk);
      rst_n = 1'b1;

      // Mask basics at full throughput.
      load_table();
      capture();
      run_stream(0, -1, -1, 0, -1, NN, cyc);
      check("throughput_cycles", DW'(cyc), DW'(NN + 1));
      check_idle("basic");

      // Fixed 4-cycle backpressure window mid-stream.
      capture();
      run_stream(0, 6, 10, 0, -1, NN, cyc);
      check("bp_cycles", DW'(cyc), DW'(NN + 5));
      check_idle("bp");

      // A capture strobe during STREAM must not disturb the mask.
      load_random();
      capture();
      run_stream(0, -1, -1, 0, 3, NN, cyc);
      check_idle("ignored");

      // Randomized passes with stalls and input gaps.
      for (int p = 0; p < 6; p++) begin
         load_random();
         capture();
         run_stream(30, -1, -1, 30, -1, NN, cyc);
         check_idle("rand");
      end

      // Reset mid-stream after 7 elements, then restart from idx 0.
      load_table();
      capture();
      run_stream(0, -1, -1, 0, -1, 7, cyc);
      grad_in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", DW'(grad_out_valid), DW'(0));
      check("mid_rst_zin_ready", DW'(zin_ready), DW'(1));
      check("mid_rst_busy", DW'(busy), DW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      load_random();
      capture();
      run_stream(20, -1, -1, 20, -1, NN, cyc);
      check_idle("restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
